// File: rtl/core_result_checker_if.sv
// Bus bundle between the result checker and the core bench: expectation table,
// register-file read port and data-memory read port.
interface core_result_checker_if #(
    parameter int XLEN   = 32,
    parameter int IDX_W  = 3,
    parameter int REG_AW = 5,
    parameter int MEM_AW = 32
);
    logic [IDX_W-1:0]  exp_idx;
    logic              exp_is_mem;
    logic [MEM_AW-1:0] exp_addr;
    logic [XLEN-1:0]   exp_value;
    logic [REG_AW-1:0] reg_raddr;
    logic [XLEN-1:0]   reg_rdata;
    logic              mem_ren;
    logic [MEM_AW-1:0] mem_raddr;
    logic [XLEN-1:0]   mem_rdata;

    modport master (
        output exp_idx, reg_raddr, mem_ren, mem_raddr,
        input  exp_is_mem, exp_addr, exp_value, reg_rdata, mem_rdata
    );

    modport slave (
        input  exp_idx, reg_raddr, mem_ren, mem_raddr,
        output exp_is_mem, exp_addr, exp_value, reg_rdata, mem_rdata
    );
endinterface

// File: rtl/core_result_checker.sv
// Self-check engine: waits RUN_CYCLES after start, then walks the expectation
// table reading the register file or data memory and tallies mismatches.
module core_result_checker #(
    parameter int XLEN       = 32,
    parameter int NUM_CHECKS = 8,
    parameter int IDX_W      = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
    parameter int RUN_CYCLES = 20,
    parameter int REG_AW     = 5,
    parameter int MEM_AW     = 32
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              start,
    core_result_checker_if.master bus,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [IDX_W:0]    fail_count,
    output logic [IDX_W-1:0]  first_fail_idx,
    output logic [XLEN-1:0]   first_fail_got
);
    localparam int CNT_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RUN_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHECKS - 1);

    typedef enum logic [2:0] {IDLE, RUN, ISSUE, MEMWAIT, CMP, DONE} state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [IDX_W-1:0]  idx, idx_nx;
    logic              hold_is_mem, hold_is_mem_nx;
    logic [XLEN-1:0]   hold_value, hold_value_nx;
    logic              forced, forced_nx;
    logic [REG_AW-1:0] reg_raddr_q, reg_raddr_nx;
    logic              mem_ren_q, mem_ren_nx;
    logic [MEM_AW-1:0] mem_raddr_q, mem_raddr_nx;
    logic [IDX_W:0]    fail_q, fail_nx;
    logic [IDX_W-1:0]  ffi_q, ffi_nx;
    logic [XLEN-1:0]   ffg_q, ffg_nx;
    logic              busy_q, busy_nx;
    logic              done_q, done_nx;
    logic              pass_q, pass_nx;
    logic [XLEN-1:0]   got;
    logic              mismatch;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            hold_is_mem <= 1'b0;
            hold_value  <= '0;
            forced      <= 1'b0;
            reg_raddr_q <= '0;
            mem_ren_q   <= 1'b0;
            mem_raddr_q <= '0;
            fail_q      <= '0;
            ffi_q       <= '0;
            ffg_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            idx         <= idx_nx;
            hold_is_mem <= hold_is_mem_nx;
            hold_value  <= hold_value_nx;
            forced      <= forced_nx;
            reg_raddr_q <= reg_raddr_nx;
            mem_ren_q   <= mem_ren_nx;
            mem_raddr_q <= mem_raddr_nx;
            fail_q      <= fail_nx;
            ffi_q       <= ffi_nx;
            ffg_q       <= ffg_nx;
            busy_q      <= busy_nx;
            done_q      <= done_nx;
            pass_q      <= pass_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (cnt == LAST_CNT) state_nx = ISSUE;
            ISSUE: begin
                if (bus.exp_is_mem && (bus.exp_addr[1:0] == 2'b00)) state_nx = MEMWAIT;
                else                                                 state_nx = CMP;
            end
            MEMWAIT: state_nx = CMP;
            CMP:     state_nx = (idx == LAST_IDX) ? DONE : ISSUE;
            DONE:    if (start) state_nx = RUN;
            default: state_nx = IDLE;
        endcase
    end

    // A misaligned memory entry never reads; it compares as a forced mismatch with got = 0.
    assign got      = forced ? '0 : (hold_is_mem ? bus.mem_rdata : bus.reg_rdata);
    assign mismatch = forced || (got != hold_value);

    always_comb begin
        cnt_nx         = cnt;
        idx_nx         = idx;
        hold_is_mem_nx = hold_is_mem;
        hold_value_nx  = hold_value;
        forced_nx      = forced;
        reg_raddr_nx   = reg_raddr_q;
        mem_ren_nx     = 1'b0;
        mem_raddr_nx   = mem_raddr_q;
        fail_nx        = fail_q;
        ffi_nx         = ffi_q;
        ffg_nx         = ffg_q;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    cnt_nx  = '0;
                    idx_nx  = '0;
                    fail_nx = '0;
                    ffi_nx  = '0;
                    ffg_nx  = '0;
                end
            end
            RUN: cnt_nx = cnt + 1'b1;
            ISSUE: begin
                hold_is_mem_nx = bus.exp_is_mem;
                hold_value_nx  = bus.exp_value;
                forced_nx      = bus.exp_is_mem && (bus.exp_addr[1:0] != 2'b00);
                if (!bus.exp_is_mem) begin
                    reg_raddr_nx = bus.exp_addr[REG_AW-1:0];
                end else if (bus.exp_addr[1:0] == 2'b00) begin
                    mem_ren_nx   = 1'b1;
                    mem_raddr_nx = bus.exp_addr;
                end
            end
            CMP: begin
                if (mismatch) begin
                    fail_nx = fail_q + 1'b1;
                    if (fail_q == '0) begin
                        ffi_nx = idx;
                        ffg_nx = got;
                    end
                end
                if (idx != LAST_IDX) idx_nx = idx + 1'b1;
            end
            default: ;
        endcase
        busy_nx = (state_nx == RUN) || (state_nx == ISSUE) ||
                  (state_nx == MEMWAIT) || (state_nx == CMP);
        done_nx = (state_nx == DONE);
        pass_nx = done_nx && (fail_nx == '0);
    end

    assign bus.exp_idx     = idx;
    assign bus.reg_raddr   = reg_raddr_q;
    assign bus.mem_ren     = mem_ren_q;
    assign bus.mem_raddr   = mem_raddr_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign fail_count      = fail_q;
    assign first_fail_idx  = ffi_q;
    assign first_fail_got  = ffg_q;
endmodule
